// File: rtl/quant_pkg.sv
// Shared quantization constants and types; dequantize takes its scale from here too.
package quant_pkg;

   localparam int unsigned DEQ_SCALE = 2408;
   localparam int unsigned SHIFT     = 24;
   localparam int unsigned INV_SCALE = 6967;   // round(2^SHIFT / DEQ_SCALE)
   localparam int          QMAX      = 127;
   localparam int          QMIN      = -128;
   localparam int unsigned VEC_LEN   = 8;      // power of two, >= 2

   localparam int unsigned DATA_W    = 32;
   localparam int unsigned CODE_W    = 8;
   localparam int unsigned PROD_W    = 48;
   localparam longint unsigned ROUND_C = 64'd1 << (SHIFT - 1);

   typedef logic signed [CODE_W-1:0] int8_t;
   typedef logic signed [DATA_W-1:0] int32_t;

   // One quantized sample: code plus its clamp flag
   typedef struct packed {
      int8_t code;
      logic  sat;
   } quant_res_t;

endpackage

// File: rtl/quant_sat_round.sv
// Combinational round/clamp: arithmetic shift of the biased product, saturate to int8.
module quant_sat_round
   import quant_pkg::*;
(
   input  logic signed [PROD_W-1:0] prod_i,
   output quant_res_t               res_c_o
);

   localparam logic signed [PROD_W-1:0] R_MAX = PROD_W'(QMAX);
   localparam logic signed [PROD_W-1:0] R_MIN = PROD_W'(QMIN);

   logic signed [PROD_W-1:0] r_c;

   // Bias was added upstream, so the shift completes round-half-up
   assign r_c = prod_i >>> SHIFT;

   // Clamp to the int8 range and flag any clamping
   always_comb begin
      res_c_o.code = r_c[CODE_W-1:0];
      res_c_o.sat  = 1'b0;
      if (r_c > R_MAX) begin
         res_c_o.code = CODE_W'(QMAX);
         res_c_o.sat  = 1'b1;
      end else if (r_c < R_MIN) begin
         res_c_o.code = CODE_W'(QMIN);
         res_c_o.sat  = 1'b1;
      end
   end

endmodule

// File: rtl/quantize.sv
// Two-stage int32 -> int8 vector quantizer with per-vector done and saturation flags.
module quantize
   import quant_pkg::*;
(
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic [DATA_W-1:0] din_i,
   input  logic              valid_i,
   output logic [CODE_W-1:0] dout_o,
   output logic              valid_o,
   output logic              sat_o,
   output logic              done_o,
   output logic              vec_sat_o
);

   localparam int unsigned CNT_W = $clog2(VEC_LEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VEC_LEN - 1);
   localparam logic signed [PROD_W-1:0] SCALE_EXT = PROD_W'(INV_SCALE);
   localparam logic signed [PROD_W-1:0] ROUND_EXT = PROD_W'(ROUND_C);

   logic signed [PROD_W-1:0] prod_d, prod_q;
   logic                     v1_q;
   logic signed [PROD_W-1:0] din_ext_c;
   quant_res_t               res_c;

   logic [CODE_W-1:0] dout_d, dout_q;
   logic              valid_d, valid_q;
   logic              sat_d, sat_q;
   logic              done_d, done_q;
   logic              vec_sat_d, vec_sat_q;
   logic [CNT_W-1:0]  cnt_d, cnt_q;
   logic              sticky_d, sticky_q;

   // Stage 1: scale by the reciprocal and add the rounding bias
   always_comb begin
      din_ext_c = PROD_W'($signed(din_i));
      prod_d    = din_ext_c * SCALE_EXT + ROUND_EXT;
   end

   quant_sat_round u_sat_round (
      .prod_i  (prod_q),
      .res_c_o (res_c)
   );

   // Stage 2 next-state: capture result, count elements, track vector saturation
   always_comb begin
      dout_d    = dout_q;
      sat_d     = sat_q;
      valid_d   = v1_q;
      done_d    = 1'b0;
      vec_sat_d = 1'b0;
      cnt_d     = cnt_q;
      sticky_d  = sticky_q;
      if (v1_q) begin
         dout_d = res_c.code;
         sat_d  = res_c.sat;
         if (cnt_q == CNT_LAST) begin
            done_d    = 1'b1;
            vec_sat_d = sticky_q | res_c.sat;
            cnt_d     = '0;
            sticky_d  = 1'b0;
         end else begin
            cnt_d    = cnt_q + CNT_W'(1);
            sticky_d = sticky_q | res_c.sat;
         end
      end
   end

   // Pipeline, counter and flag registers
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         prod_q    <= '0;
         v1_q      <= 1'b0;
         dout_q    <= '0;
         valid_q   <= 1'b0;
         sat_q     <= 1'b0;
         done_q    <= 1'b0;
         vec_sat_q <= 1'b0;
         cnt_q     <= '0;
         sticky_q  <= 1'b0;
      end else begin
         prod_q    <= prod_d;
         v1_q      <= valid_i;
         dout_q    <= dout_d;
         valid_q   <= valid_d;
         sat_q     <= sat_d;
         done_q    <= done_d;
         vec_sat_q <= vec_sat_d;
         cnt_q     <= cnt_d;
         sticky_q  <= sticky_d;
      end
   end

   assign dout_o    = dout_q;
   assign valid_o   = valid_q;
   assign sat_o     = sat_q;
   assign done_o    = done_q;
   assign vec_sat_o = vec_sat_q;

endmodule

// File: tb/tb_quantize.sv
// Scoreboard bench for quantize: expectations queued at drive time, checked on valid_o.
module tb_quantize;
   import quant_pkg::*;

   logic        clk_i = 1'b0;
   logic        rstn_i = 1'b0;
   logic [31:0] din_i = '0;
   logic        valid_i = 1'b0;
   logic [7:0]  dout_o;
   logic        valid_o, sat_o, done_o, vec_sat_o;

   quantize dut (
      .clk_i     (clk_i),
      .rstn_i    (rstn_i),
      .din_i     (din_i),
      .valid_i   (valid_i),
      .dout_o    (dout_o),
      .valid_o   (valid_o),
      .sat_o     (sat_o),
      .done_o    (done_o),
      .vec_sat_o (vec_sat_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int8_t code;
      bit    sat;
      bit    done;
      bit    vsat;
      int    cyc;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_errors = 0;
   int          n_out = 0;
   int          m_cnt = 0;
   bit          m_sticky = 1'b0;
   logic [7:0]  last_dout = '0;
   logic        last_sat = 1'b0;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check_val(input string tag, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Reference: round-half-up of x * INV_SCALE / 2^SHIFT, clamped to int8
   function automatic void model(input int x, output int code, output bit sat);
      longint p;
      longint r;
      p = longint'(x) * longint'(INV_SCALE) + (longint'(1) <<< (SHIFT - 1));
      r = p >>> SHIFT;
      sat = 1'b0;
      code = int'(r);
      if (r > 127) begin code = 127; sat = 1'b1; end
      else if (r < -128) begin code = -128; sat = 1'b1; end
   endfunction

   // Drive one sample for one cycle and queue its expected output
   task automatic send(input int x, input int exp_code, input bit exp_sat);
      exp_t e;
      bit   last;
      last   = (m_cnt == int'(VEC_LEN) - 1);
      e.code = 8'(exp_code);
      e.sat  = exp_sat;
      e.done = last;
      e.vsat = last & (m_sticky | exp_sat);
      e.cyc  = cyc + 2;
      if (last) begin
         m_cnt = 0;
         m_sticky = 1'b0;
      end else begin
         m_cnt++;
         m_sticky = m_sticky | exp_sat;
      end
      sb.push_back(e);
      din_i   = 32'(x);
      valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
      din_i   = $urandom();
   endtask

   task automatic send_m(input int x);
      int c;
      bit s;
      model(x, c, s);
      send(x, c, s);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
      check_val("drain_left", sb.size(), 0);
   endtask

   // Output monitor: compare against scoreboard, and check idle-cycle behaviour
   always @(negedge clk_i) begin
      if (rstn_i) begin
         if (valid_o) begin
            if (sb.size() == 0) begin
               check_val("unexpected_valid", 1, 0);
            end else begin
               mon_e = sb.pop_front();
               check_val("code", longint'($signed(dout_o)), longint'(mon_e.code));
               check_val("sat", sat_o, mon_e.sat);
               check_val("done", done_o, mon_e.done);
               check_val("vec_sat", vec_sat_o, mon_e.vsat);
               check_val("latency", cyc, mon_e.cyc);
            end
            n_out++;
            last_dout = dout_o;
            last_sat  = sat_o;
         end else begin
            check_val("done_idle", done_o, 0);
            check_val("vec_sat_idle", vec_sat_o, 0);
            check_val("dout_hold", dout_o, last_dout);
            check_val("sat_hold", sat_o, last_sat);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   int rt_k[8]    = '{0, 1, -1, 5, -5, 127, -128, 64};
   int v2_x[8]    = '{1204, 1205, -1204, -1205, 400000, -400000,
                      int'(32'h7FFF_FFFF), int'(32'h8000_0000)};
   int v2_code[8] = '{0, 1, 0, -1, 127, -128, 127, -128};
   bit v2_sat[8]  = '{0, 0, 0, 0, 1, 1, 1, 1};

   initial begin
      int k;
      int base;

      // Reset state
      #12;
      check_val("rst_dout", dout_o, 0);
      check_val("rst_valid", valid_o, 0);
      check_val("rst_sat", sat_o, 0);
      check_val("rst_done", done_o, 0);
      check_val("rst_vec_sat", vec_sat_o, 0);
      @(posedge clk_i);
      #1;
      rstn_i = 1'b1;
      idle(1);

      // Round trip, back-to-back
      foreach (rt_k[i]) send(2408 * rt_k[i], rt_k[i], 1'b0);

      // Rounding and saturation in one vector
      foreach (v2_x[i]) send(v2_x[i], v2_code[i], v2_sat[i]);

      // Clean random round-trip vector
      for (int i = 0; i < 8; i++) begin
         k = int'($urandom_range(255, 0)) - 128;
         send(2408 * k, k, 1'b0);
      end

      // Gapped valid with random values
      for (int i = 0; i < 8; i++) begin
         send_m(int'($urandom_range(600000, 0)) - 300000);
         idle(int'($urandom_range(3, 0)));
      end

      // Saturation on the last element, then a clean vector
      for (int i = 0; i < 7; i++) send(2408 * (i * 10 - 30), i * 10 - 30, 1'b0);
      send(500000, 127, 1'b1);
      for (int i = 0; i < 8; i++) send(2408 * (i * 3 - 11), i * 3 - 11, 1'b0);
      drain();

      // Reset mid-vector after five outputs
      base = n_out;
      for (int i = 0; i < 6; i++) send(2408 * (i + 1), i + 1, 1'b0);
      for (int i = 0; i < 20 && n_out < base + 5; i++) begin
         @(negedge clk_i);
         #1;
      end
      check_val("outs_before_reset", n_out - base, 5);
      #1;
      rstn_i = 1'b0;
      #1;
      check_val("mid_rst_dout", dout_o, 0);
      check_val("mid_rst_valid", valid_o, 0);
      check_val("mid_rst_sat", sat_o, 0);
      check_val("mid_rst_done", done_o, 0);
      check_val("mid_rst_vec_sat", vec_sat_o, 0);
      sb.delete();
      m_cnt = 0;
      m_sticky = 1'b0;
      last_dout = '0;
      last_sat = 1'b0;
      @(posedge clk_i);
      #1;
      rstn_i = 1'b1;
      idle(1);

      // Fresh vector: done must come with the 8th output
      for (int i = 0; i < 8; i++) send(2408 * (50 - i * 7), 50 - i * 7, 1'b0);
      drain();
      idle(2);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
